// File: rtl/vfu_mask_distributor.sv
// Per-lane mask distributor: routes tagged mask beats from the mask unit into
// one small per-FU queue, selected by matching the beat's instruction ID.
module vfu_mask_distributor #(
    parameter int unsigned NrFUs          = 2,
    parameter int unsigned MaskQueueDepth = 2,
    parameter bit          FallThrough    = 1'b0,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned VidWidth       = 3
) (
    input  logic                                               clk_i,
    input  logic                                               rst_ni,
    input  logic [DataWidth/8-1:0]                             mask_i,
    input  logic [VidWidth-1:0]                                mask_vid_i,
    input  logic                                               mask_valid_i,
    output logic                                               mask_ready_o,
    input  logic [NrFUs-1:0][VidWidth-1:0]                     fu_vid_i,
    input  logic [NrFUs-1:0]                                   fu_vid_valid_i,
    input  logic [NrFUs-1:0]                                   fu_flush_i,
    output logic [NrFUs-1:0][DataWidth/8-1:0]                  fu_mask_o,
    output logic [NrFUs-1:0]                                   fu_mask_valid_o,
    input  logic [NrFUs-1:0]                                   fu_mask_ready_i,
    output logic [NrFUs-1:0][$clog2(MaskQueueDepth+1)-1:0]     fu_mask_cnt_o,
    output logic                                               tag_conflict_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned CntW  = $clog2(MaskQueueDepth + 1);
    localparam int unsigned PtrW  = (MaskQueueDepth > 1) ? $clog2(MaskQueueDepth) : 1;
    localparam int unsigned TgtW  = (NrFUs > 1) ? $clog2(NrFUs) : 1;

    typedef logic [PtrW-1:0] ptr_t;

    logic [NrFUs-1:0] match;
    logic [NrFUs-1:0] push;
    logic [NrFUs-1:0] ft;
    logic [NrFUs-1:0] bypass;
    logic [NrFUs-1:0] store;
    logic [NrFUs-1:0] empty;
    logic [NrFUs-1:0] pop;
    logic [NrFUs-1:0] pop_mem;
    logic [TgtW-1:0]  target;
    logic             any_match;
    logic             multi_match;
    logic             target_full;

    logic [StrbW-1:0] mem    [NrFUs][MaskQueueDepth];
    ptr_t             rd_ptr [NrFUs];
    ptr_t             wr_ptr [NrFUs];
    logic [CntW-1:0]  cnt_q  [NrFUs];
    logic [StrbW-1:0] last_q [NrFUs];
    logic             conflict_q;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(MaskQueueDepth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Lowest-index matching FU wins; extra matches only raise the conflict flag.
    always_comb begin
        match       = '0;
        any_match   = 1'b0;
        multi_match = 1'b0;
        target      = '0;
        for (int f = 0; f < NrFUs; f++) begin
            match[f] = fu_vid_valid_i[f] && (fu_vid_i[f] == mask_vid_i);
            if (match[f]) begin
                if (any_match) multi_match = 1'b1;
                else           target      = TgtW'(f);
                any_match = 1'b1;
            end
        end
    end

    // Handshakes: a beat transfers on a cycle where valid && ready are both high.
    // Ready never looks at the same-side valid, and mask_ready_o uses only the
    // registered occupancy, so a same-cycle pop cannot open a full queue.
    assign target_full  = (cnt_q[target] >= CntW'(MaskQueueDepth));
    assign mask_ready_o = any_match && !target_full && !fu_flush_i[target];
    assign tag_conflict_o = conflict_q;

    always_comb begin
        push            = '0;
        ft              = '0;
        bypass          = '0;
        store           = '0;
        empty           = '0;
        pop             = '0;
        pop_mem         = '0;
        fu_mask_o       = '0;
        fu_mask_valid_o = '0;
        fu_mask_cnt_o   = '0;
        for (int f = 0; f < NrFUs; f++) begin
            empty[f]   = (cnt_q[f] == '0);
            push[f]    = mask_valid_i && mask_ready_o && (target == TgtW'(f));
            ft[f]      = FallThrough && empty[f] && push[f];
            fu_mask_valid_o[f] = !empty[f] || ft[f];
            pop[f]     = fu_mask_valid_o[f] && fu_mask_ready_i[f];
            bypass[f]  = ft[f] && fu_mask_ready_i[f];
            store[f]   = push[f] && !bypass[f];
            pop_mem[f] = pop[f] && !empty[f];
            // When idle the last delivered beat is held on the output.
            if (ft[f])          fu_mask_o[f] = mask_i;
            else if (!empty[f]) fu_mask_o[f] = mem[f][rd_ptr[f]];
            else                fu_mask_o[f] = last_q[f];
            fu_mask_cnt_o[f] = cnt_q[f];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q <= 1'b0;
            for (int f = 0; f < NrFUs; f++) begin
                cnt_q[f]  <= '0;
                rd_ptr[f] <= '0;
                wr_ptr[f] <= '0;
                last_q[f] <= '0;
                for (int d = 0; d < MaskQueueDepth; d++) mem[f][d] <= '0;
            end
        end else begin
            if (mask_valid_i && multi_match) conflict_q <= 1'b1;
            for (int f = 0; f < NrFUs; f++) begin
                if (pop[f]) last_q[f] <= fu_mask_o[f];
                if (fu_flush_i[f]) begin
                    cnt_q[f]  <= '0;
                    rd_ptr[f] <= '0;
                    wr_ptr[f] <= '0;
                end else begin
                    if (store[f]) begin
                        mem[f][wr_ptr[f]] <= mask_i;
                        wr_ptr[f]         <= ptr_inc(wr_ptr[f]);
                    end
                    if (pop_mem[f]) rd_ptr[f] <= ptr_inc(rd_ptr[f]);
                    cnt_q[f] <= cnt_q[f] + CntW'(store[f]) - CntW'(pop_mem[f]);
                end
            end
        end
    end

endmodule

// File: tb/tb_vfu_mask_distributor.sv
// Self-checking bench for vfu_mask_distributor: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_vfu_mask_distributor;

    localparam int NF = 2;
    localparam int SW = 8;
    localparam int VW = 3;
    localparam int CW = 2;
    localparam int DEPTH = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [SW-1:0]          mask;
    logic [VW-1:0]          mask_vid;
    logic                   mask_valid;
    logic [NF-1:0][VW-1:0]  fu_vid;
    logic [NF-1:0]          fu_vid_valid;
    logic [NF-1:0]          fu_flush;
    logic [NF-1:0]          fu_ready;

    logic                   mask_ready,    mask_ready_ft;
    logic [NF-1:0][SW-1:0]  fu_mask,       fu_mask_ft;
    logic [NF-1:0]          fu_mask_valid, fu_mask_valid_ft;
    logic [NF-1:0][CW-1:0]  fu_cnt,        fu_cnt_ft;
    logic                   tag_conflict,  tag_conflict_ft;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vfu_mask_distributor #(.NrFUs(NF), .MaskQueueDepth(DEPTH), .FallThrough(1'b0),
                           .DataWidth(64), .VidWidth(VW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mask_i(mask), .mask_vid_i(mask_vid),
        .mask_valid_i(mask_valid), .mask_ready_o(mask_ready), .fu_vid_i(fu_vid),
        .fu_vid_valid_i(fu_vid_valid), .fu_flush_i(fu_flush), .fu_mask_o(fu_mask),
        .fu_mask_valid_o(fu_mask_valid), .fu_mask_ready_i(fu_ready),
        .fu_mask_cnt_o(fu_cnt), .tag_conflict_o(tag_conflict));

    vfu_mask_distributor #(.NrFUs(NF), .MaskQueueDepth(DEPTH), .FallThrough(1'b1),
                           .DataWidth(64), .VidWidth(VW)) dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .mask_i(mask), .mask_vid_i(mask_vid),
        .mask_valid_i(mask_valid), .mask_ready_o(mask_ready_ft), .fu_vid_i(fu_vid),
        .fu_vid_valid_i(fu_vid_valid), .fu_flush_i(fu_flush), .fu_mask_o(fu_mask_ft),
        .fu_mask_valid_o(fu_mask_valid_ft), .fu_mask_ready_i(fu_ready),
        .fu_mask_cnt_o(fu_cnt_ft), .tag_conflict_o(tag_conflict_ft));

    task automatic idle();
        mask = '0; mask_vid = '0; mask_valid = 1'b0;
        fu_vid = '0; fu_vid_valid = '0; fu_flush = '0; fu_ready = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (fu_mask_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b exp 00", fu_mask_valid); end
        checks++; if (fu_mask !== '0) begin errors++; $display("FAIL reset_mask: got %h exp 0", fu_mask); end
        checks++; if (fu_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", fu_cnt); end
        checks++; if (tag_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b exp 0", tag_conflict); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (mask_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_idle: got %b exp 0", mask_ready); end
    endtask

    task automatic test_routing();
        apply_reset();
        fu_vid[0] = 3'd3; fu_vid[1] = 3'd5; fu_vid_valid = 2'b11; fu_ready = 2'b11;
        mask = 8'hA5; mask_vid = 3'd5; mask_valid = 1'b1;
        #1;
        checks++; if (mask_ready !== 1'b1) begin errors++; $display("FAIL route_ready1: got %b exp 1", mask_ready); end
        @(posedge clk); @(negedge clk);
        mask = 8'h0F; mask_vid = 3'd3;
        #1;
        checks++; if (fu_mask_valid !== 2'b10) begin errors++; $display("FAIL route_valid1: got %b exp 10", fu_mask_valid); end
        checks++; if (fu_mask[1] !== 8'hA5) begin errors++; $display("FAIL route_mask1: got %h exp a5", fu_mask[1]); end
        checks++; if (mask_ready !== 1'b1) begin errors++; $display("FAIL route_ready0: got %b exp 1", mask_ready); end
        @(posedge clk); @(negedge clk);
        mask_valid = 1'b0;
        #1;
        checks++; if (fu_mask_valid !== 2'b01) begin errors++; $display("FAIL route_valid0: got %b exp 01", fu_mask_valid); end
        checks++; if (fu_mask[0] !== 8'h0F) begin errors++; $display("FAIL route_mask0: got %h exp 0f", fu_mask[0]); end
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        apply_reset();
        fu_vid[0] = 3'd1; fu_vid[1] = 3'd2; fu_vid_valid = 2'b11; fu_ready = 2'b00;
        mask_vid = 3'd1; mask_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mask = beats[i];
            #1;
            checks++; if (mask_ready !== (i < 2)) begin errors++; $display("FAIL bp_ready_%0d: got %b exp %b", i, mask_ready, (i < 2)); end
            checks++; if (fu_cnt[0] !== CW'(i)) begin errors++; $display("FAIL bp_cnt_%0d: got %0d exp %0d", i, fu_cnt[0], i); end
            @(posedge clk); @(negedge clk);
        end
        fu_ready[0] = 1'b1;
        #1;
        checks++; if (mask_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b exp 0", mask_ready); end
        checks++; if (fu_mask[0] !== 8'h11) begin errors++; $display("FAIL bp_head0: got %h exp 11", fu_mask[0]); end
        @(posedge clk); @(negedge clk);
        #1;
        checks++; if (mask_ready !== 1'b1) begin errors++; $display("FAIL bp_third_ready: got %b exp 1", mask_ready); end
        checks++; if (fu_mask[0] !== 8'h22) begin errors++; $display("FAIL bp_head1: got %h exp 22", fu_mask[0]); end
        @(posedge clk); @(negedge clk);
        mask_valid = 1'b0;
        #1;
        checks++; if (fu_mask[0] !== 8'h33) begin errors++; $display("FAIL bp_head2: got %h exp 33", fu_mask[0]); end
        checks++; if (fu_cnt[0] !== 2'd1) begin errors++; $display("FAIL bp_cnt_drain: got %0d exp 1", fu_cnt[0]); end
        @(posedge clk); @(negedge clk);
        checks++; if (fu_mask_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b exp 0", fu_mask_valid[0]); end
    endtask

    task automatic test_unmatched();
        apply_reset();
        fu_vid[0] = 3'd1; fu_vid[1] = 3'd2; fu_vid_valid = 2'b11; fu_ready = 2'b00;
        mask = 8'hC3; mask_vid = 3'd7; mask_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mask_ready !== 1'b0) begin errors++; $display("FAIL unmatched_stall_%0d: got %b exp 0", i, mask_ready); end
            @(posedge clk); @(negedge clk);
        end
        fu_vid[1] = 3'd7;
        #1;
        checks++; if (mask_ready !== 1'b1) begin errors++; $display("FAIL unmatched_accept: got %b exp 1", mask_ready); end
        @(posedge clk); @(negedge clk);
        mask_valid = 1'b0;
        #1;
        checks++; if (fu_mask_valid !== 2'b10) begin errors++; $display("FAIL unmatched_valid: got %b exp 10", fu_mask_valid); end
        checks++; if (fu_mask[1] !== 8'hC3) begin errors++; $display("FAIL unmatched_mask: got %h exp c3", fu_mask[1]); end
    endtask

    task automatic test_flush();
        logic [SW-1:0] beats [3];
        logic [VW-1:0] tags  [3];
        beats[0] = 8'h44; beats[1] = 8'h55; beats[2] = 8'h66;
        tags[0] = 3'd2;   tags[1] = 3'd2;   tags[2] = 3'd1;
        apply_reset();
        fu_vid[0] = 3'd1; fu_vid[1] = 3'd2; fu_vid_valid = 2'b11; fu_ready = 2'b00;
        mask_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mask = beats[i]; mask_vid = tags[i];
            @(posedge clk); @(negedge clk);
        end
        fu_flush[1] = 1'b1; fu_ready[1] = 1'b1; mask = 8'h77; mask_vid = 3'd2;
        #1;
        checks++; if (mask_ready !== 1'b0) begin errors++; $display("FAIL flush_push_block: got %b exp 0", mask_ready); end
        checks++; if (fu_cnt[1] !== 2'd2) begin errors++; $display("FAIL flush_pre_cnt: got %0d exp 2", fu_cnt[1]); end
        @(posedge clk); @(negedge clk);
        fu_flush = '0; fu_ready = '0; mask_valid = 1'b0;
        #1;
        checks++; if (fu_cnt[1] !== 2'd0) begin errors++; $display("FAIL flush_cnt: got %0d exp 0", fu_cnt[1]); end
        checks++; if (fu_mask_valid !== 2'b01) begin errors++; $display("FAIL flush_valid: got %b exp 01", fu_mask_valid); end
        checks++; if (fu_cnt[0] !== 2'd1) begin errors++; $display("FAIL flush_other_cnt: got %0d exp 1", fu_cnt[0]); end
        checks++; if (fu_mask[0] !== 8'h66) begin errors++; $display("FAIL flush_other_mask: got %h exp 66", fu_mask[0]); end
    endtask

    task automatic test_fallthrough();
        apply_reset();
        fu_vid[0] = 3'd4; fu_vid[1] = 3'd6; fu_vid_valid = 2'b11; fu_ready = 2'b01;
        mask = 8'h3C; mask_vid = 3'd4; mask_valid = 1'b1;
        #1;
        checks++; if (fu_mask_valid_ft[0] !== 1'b1) begin errors++; $display("FAIL ft_valid: got %b exp 1", fu_mask_valid_ft[0]); end
        checks++; if (fu_mask_ft[0] !== 8'h3C) begin errors++; $display("FAIL ft_mask: got %h exp 3c", fu_mask_ft[0]); end
        checks++; if (fu_mask_valid[0] !== 1'b0) begin errors++; $display("FAIL noft_latency: got %b exp 0", fu_mask_valid[0]); end
        @(posedge clk); @(negedge clk);
        mask = 8'h5A; mask_vid = 3'd6;
        #1;
        checks++; if (fu_cnt_ft[0] !== 2'd0) begin errors++; $display("FAIL ft_bypass_cnt: got %0d exp 0", fu_cnt_ft[0]); end
        checks++; if (fu_mask_valid_ft[0] !== 1'b0) begin errors++; $display("FAIL ft_bypass_gone: got %b exp 0", fu_mask_valid_ft[0]); end
        checks++; if (fu_mask[0] !== 8'h3C) begin errors++; $display("FAIL noft_mask: got %h exp 3c", fu_mask[0]); end
        checks++; if (fu_mask_ft[1] !== 8'h5A) begin errors++; $display("FAIL ft_mask_noready: got %h exp 5a", fu_mask_ft[1]); end
        @(posedge clk); @(negedge clk);
        mask_valid = 1'b0;
        #1;
        checks++; if (fu_cnt_ft[1] !== 2'd1) begin errors++; $display("FAIL ft_store_cnt: got %0d exp 1", fu_cnt_ft[1]); end
        checks++; if (fu_mask_ft[1] !== 8'h5A) begin errors++; $display("FAIL ft_store_mask: got %h exp 5a", fu_mask_ft[1]); end
    endtask

    task automatic test_conflict_reset();
        apply_reset();
        fu_vid[0] = 3'd2; fu_vid[1] = 3'd2; fu_vid_valid = 2'b11; fu_ready = 2'b00;
        mask = 8'h99; mask_vid = 3'd2; mask_valid = 1'b1;
        #1;
        checks++; if (tag_conflict !== 1'b0) begin errors++; $display("FAIL conflict_early: got %b exp 0", tag_conflict); end
        @(posedge clk); @(negedge clk);
        mask_valid = 1'b0;
        #1;
        checks++; if (tag_conflict !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b exp 1", tag_conflict); end
        checks++; if (fu_mask_valid !== 2'b01) begin errors++; $display("FAIL conflict_route: got %b exp 01", fu_mask_valid); end
        checks++; if (fu_mask[0] !== 8'h99) begin errors++; $display("FAIL conflict_mask: got %h exp 99", fu_mask[0]); end
        fu_vid[1] = 3'd0;
        @(posedge clk); @(negedge clk);
        checks++; if (tag_conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b exp 1", tag_conflict); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fu_mask_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_valid: got %b exp 00", fu_mask_valid); end
        checks++; if (fu_mask !== '0) begin errors++; $display("FAIL rst_mid_mask: got %h exp 0", fu_mask); end
        checks++; if (fu_cnt !== '0) begin errors++; $display("FAIL rst_mid_cnt: got %h exp 0", fu_cnt); end
        checks++; if (tag_conflict !== 1'b0) begin errors++; $display("FAIL rst_mid_conflict: got %b exp 0", tag_conflict); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: one FIFO of beats per FU, plus a sticky conflict flag.
    task automatic test_random();
        logic [SW-1:0] exp_q [NF][$];
        logic          exp_conflict;
        int            tgt;
        int            nmatch;
        logic          exp_ready;
        apply_reset();
        exp_conflict = 1'b0;
        for (int f = 0; f < NF; f++) exp_q[f].delete();
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int f = 0; f < NF; f++) begin
                fu_vid[f]       = VW'($urandom_range(0, 3));
                fu_vid_valid[f] = ($urandom_range(0, 3) != 0);
                fu_flush[f]     = ($urandom_range(0, 15) == 0);
                fu_ready[f]     = ($urandom_range(0, 2) == 0);
            end
            mask       = SW'($urandom);
            mask_vid   = VW'($urandom_range(0, 3));
            mask_valid = ($urandom_range(0, 3) != 0);
            #1;
            tgt = -1; nmatch = 0;
            for (int f = 0; f < NF; f++)
                if (fu_vid_valid[f] && fu_vid[f] == mask_vid) begin
                    if (tgt < 0) tgt = f;
                    nmatch++;
                end
            exp_ready = (tgt >= 0) && (exp_q[tgt].size() < DEPTH) && !fu_flush[tgt];
            checks++; if (mask_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b exp %b", cyc, mask_ready, exp_ready); end
            checks++; if (tag_conflict !== exp_conflict) begin errors++; $display("FAIL rand_conflict c%0d: got %b exp %b", cyc, tag_conflict, exp_conflict); end
            for (int f = 0; f < NF; f++) begin
                checks++; if (fu_cnt[f] !== CW'(exp_q[f].size())) begin errors++; $display("FAIL rand_cnt%0d c%0d: got %0d exp %0d", f, cyc, fu_cnt[f], exp_q[f].size()); end
                checks++; if (fu_mask_valid[f] !== (exp_q[f].size() != 0)) begin errors++; $display("FAIL rand_valid%0d c%0d: got %b exp %b", f, cyc, fu_mask_valid[f], exp_q[f].size() != 0); end
                if (exp_q[f].size() != 0) begin
                    checks++; if (fu_mask[f] !== exp_q[f][0]) begin errors++; $display("FAIL rand_mask%0d c%0d: got %h exp %h", f, cyc, fu_mask[f], exp_q[f][0]); end
                end
            end
            for (int f = 0; f < NF; f++) begin
                if (fu_flush[f]) exp_q[f].delete();
                else if (fu_ready[f] && exp_q[f].size() != 0) void'(exp_q[f].pop_front());
            end
            if (mask_valid && exp_ready) exp_q[tgt].push_back(mask);
            if (mask_valid && nmatch > 1) exp_conflict = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_routing();
        test_backpressure();
        test_unmatched();
        test_flush();
        test_fallthrough();
        test_conflict_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
